// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory bus between two requesters.
// Every access runs IDLE -> ADDR -> DATA -> ACK. Ties are broken round-robin.
// The address map is enforced: ROM writes and accesses to the unmapped hole
// are blocked and reported through errN.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   reqN_i, addrN_i, wdataN_i,  requester N (N = 0, 1); request plus its
//   writeN_i                    address, write data and direction
//   ackN_o, rdataN_o, errN_o    one-cycle completion, read data, denied flag
//   busy_o                      high whenever an access is in progress
//   mem_address_o, mem_data_in_o, mem_write_o, mem_data_out_i
//                               memory bus; read data arrives one clock
//                               after the address is presented
module mem_arbiter #(
  parameter logic [7:0] ROM_TOP   = 8'h7F,
  parameter logic [7:0] RAM_TOP   = 8'hDF,
  parameter logic [7:0] PORT_BASE = 8'hF0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] addr0_i,
  input  logic [7:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  input  logic       write0_i,
  input  logic       write1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [7:0] rdata0_o,
  output logic [7:0] rdata1_o,
  output logic       err0_o,
  output logic       err1_o,
  output logic       busy_o,
  output logic [7:0] mem_address_o,
  output logic [7:0] mem_data_in_o,
  output logic       mem_write_o,
  input  logic [7:0] mem_data_out_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       grant_q, grant_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       deny_q, deny_d;
  logic       unmapped_q, unmapped_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;

  // Candidate grant: a lone request wins outright, a tie goes to prio.
  logic       grantSel;
  logic [7:0] selAddr;
  logic [7:0] selWdata;
  logic       selWrite;
  logic       selUnmapped;
  logic       selDeny;

  assign grantSel    = (req0_i && req1_i) ? prio_q : req1_i;
  assign selAddr     = grantSel ? addr1_i  : addr0_i;
  assign selWdata    = grantSel ? wdata1_i : wdata0_i;
  assign selWrite    = grantSel ? write1_i : write0_i;
  assign selUnmapped = (selAddr > RAM_TOP) && (selAddr < PORT_BASE);
  assign selDeny     = selUnmapped || (selWrite && (selAddr <= ROM_TOP));

  // Next-state logic. The request is latched at grant so later changes on
  // the requester side cannot disturb an access already in flight.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    deny_d     = deny_q;
    unmapped_d = unmapped_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          grant_d    = grantSel;
          addr_d     = selAddr;
          wdata_d    = selWdata;
          write_d    = selWrite;
          deny_d     = selDeny;
          unmapped_d = selUnmapped;
          prio_d     = ~grantSel;
          state_d    = ADDR;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        // Memory data is valid now, one clock after the address went out.
        if (grant_q) rdata1_d = unmapped_q ? 8'h00 : mem_data_out_i;
        else         rdata0_d = unmapped_q ? 8'h00 : mem_data_out_i;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      grant_q    <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      write_q    <= 1'b0;
      deny_q     <= 1'b0;
      unmapped_q <= 1'b0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      deny_q     <= deny_d;
      unmapped_q <= unmapped_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // The latched address/data double as the bus drive, so the bus holds its
  // last values while idle. Strobes are decoded from state, which makes a
  // reset in ADDR drop mem_write on that same edge.
  assign mem_address_o = addr_q;
  assign mem_data_in_o = wdata_q;
  assign mem_write_o   = (state_q == ADDR) && write_q && !deny_q;
  assign busy_o        = (state_q != IDLE);
  assign ack0_o        = (state_q == ACK) && !grant_q;
  assign ack1_o        = (state_q == ACK) && grant_q;
  assign err0_o        = ack0_o && deny_q;
  assign err1_o        = ack1_o && deny_q;
  assign rdata0_o      = rdata0_q;
  assign rdata1_o      = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A small synchronous memory model answers one clock after the address.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [7:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       write0, write1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       err0, err1;
  logic       busy;
  logic [7:0] memAddress;
  logic [7:0] memDataIn;
  logic       memWrite;
  logic [7:0] memDataOut;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] memArr [256];
  int         writeCount;
  int         busyCount;
  logic [7:0] lastWrAddr;
  logic [7:0] lastWrData;

  mem_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req0_i         (req0),
    .req1_i         (req1),
    .addr0_i        (addr0),
    .addr1_i        (addr1),
    .wdata0_i       (wdata0),
    .wdata1_i       (wdata1),
    .write0_i       (write0),
    .write1_i       (write1),
    .ack0_o         (ack0),
    .ack1_o         (ack1),
    .rdata0_o       (rdata0),
    .rdata1_o       (rdata1),
    .err0_o         (err0),
    .err1_o         (err1),
    .busy_o         (busy),
    .mem_address_o  (memAddress),
    .mem_data_in_o  (memDataIn),
    .mem_write_o    (memWrite),
    .mem_data_out_i (memDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, so data follows the address by one clock.
  always @(posedge clk) begin
    if (memWrite) memArr[memAddress] <= memDataIn;
    memDataOut <= memArr[memAddress];
  end

  // Bus monitor: counts write strobes and busy cycles for each transaction.
  always @(negedge clk) begin
    if (memWrite) begin
      writeCount = writeCount + 1;
      lastWrAddr = memAddress;
      lastWrData = memDataIn;
    end
    if (busy) busyCount = busyCount + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    if (obs !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the given port's ack; cyc is the number of falling edges
  // taken, or 0 when the budget runs out.
  task automatic waitAck(input bit port, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One complete transaction on an idle arbiter, checked end to end.
  task automatic applyStimulus(input bit port, input logic [7:0] a, input logic [7:0] d,
                               input bit w, input int expWrites, input bit expErr,
                               input bit chkRd, input logic [7:0] expRd, input string tag);
    int lat;
    if (port) begin
      req1 = 1'b1; addr1 = a; wdata1 = d; write1 = w;
    end else begin
      req0 = 1'b1; addr0 = a; wdata0 = d; write0 = w;
    end
    writeCount = 0;
    busyCount  = 0;
    waitAck(port, 8, lat);
    checkOutput({tag, "_latency"}, lat, 3);
    checkOutput({tag, "_err"}, port ? err1 : err0, expErr);
    checkOutput({tag, "_otherack"}, port ? ack0 : ack1, 0);
    if (chkRd) checkOutput({tag, "_rdata"}, port ? rdata1 : rdata0, expRd);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, busy, 0);
    checkOutput({tag, "_busycycles"}, busyCount, 3);
    checkOutput({tag, "_writes"}, writeCount, expWrites);
    if (expWrites > 0) begin
      checkOutput({tag, "_wraddr"}, lastWrAddr, a);
      checkOutput({tag, "_wrdata"}, lastWrData, d);
    end
  endtask

  int expPort [6] = '{0, 1, 0, 1, 1, 1};
  int lat;
  int prevCyc;
  int nAck;
  int port;

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 8'h00;
    memArr[8'h05] = 8'hA5;
    memArr[8'h81] = 8'h5A;
    memArr[8'h10] = 8'h11;
    memArr[8'hE8] = 8'h77;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00;
    wdata0 = 8'h00; wdata1 = 8'h00;
    write0 = 1'b0; write1 = 1'b0;
    writeCount = 0; busyCount = 0;
    lastWrAddr = 8'h00; lastWrData = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ack0", ack0, 0);
    checkOutput("rst_ack1", ack1, 0);
    checkOutput("rst_err0", err0, 0);
    checkOutput("rst_err1", err1, 0);
    checkOutput("rst_memwrite", memWrite, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_memaddr", memAddress, 8'h00);
    checkOutput("rst_memdata", memDataIn, 8'h00);
    checkOutput("rst_rdata0", rdata0, 8'h00);
    checkOutput("rst_rdata1", rdata1, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic reads and writes");
    applyStimulus(0, 8'h05, 8'h00, 0, 0, 0, 1, 8'hA5, "rd05");
    applyStimulus(1, 8'h90, 8'h3C, 1, 1, 0, 0, 8'h00, "wr90");
    checkOutput("wr90_mem", memArr[8'h90], 8'h3C);
    applyStimulus(1, 8'hF3, 8'h55, 1, 1, 0, 0, 8'h00, "wrF3");
    checkOutput("wrF3_mem", memArr[8'hF3], 8'h55);

    $display("[TB] address map enforcement");
    applyStimulus(0, 8'h10, 8'hEE, 1, 0, 1, 0, 8'h00, "wr10");
    checkOutput("wr10_mem", memArr[8'h10], 8'h11);
    applyStimulus(1, 8'hE5, 8'h66, 1, 0, 1, 0, 8'h00, "wrE5");
    applyStimulus(0, 8'hE8, 8'h00, 0, 0, 1, 1, 8'h00, "rdE8");
    applyStimulus(1, 8'h10, 8'h00, 0, 0, 0, 1, 8'h11, "rd10");

    $display("[TB] continuous contention from reset");
    reset = 1'b1;
    req0 = 1'b1; addr0 = 8'h05; write0 = 1'b0;
    req1 = 1'b1; addr1 = 8'h81; write1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prevCyc = 0;
    nAck = 0;
    for (int cyc = 1; cyc <= 60 && nAck < 6; cyc++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        port = ack1 ? 1 : 0;
        checkOutput($sformatf("rr_port%0d", nAck), port, expPort[nAck]);
        checkOutput($sformatf("rr_onehot%0d", nAck), ack0 && ack1, 0);
        checkOutput($sformatf("rr_gap%0d", nAck), cyc - prevCyc, (nAck == 0) ? 3 : 4);
        checkOutput($sformatf("rr_rdata%0d", nAck), port ? rdata1 : rdata0,
                    port ? 8'h5A : 8'hA5);
        prevCyc = cyc;
        nAck = nAck + 1;
        if (nAck == 4) req0 = 1'b0;
      end
    end
    checkOutput("rr_count", nAck, 6);
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("rr_idle", busy, 0);

    $display("[TB] reset during ADDR");
    req0 = 1'b1; addr0 = 8'h90; wdata0 = 8'hAA; write0 = 1'b1;
    @(negedge clk);
    checkOutput("abort_prewrite", memWrite, 1);
    reset = 1'b1;
    req1 = 1'b1; addr1 = 8'h05; write1 = 1'b0;
    @(negedge clk);
    checkOutput("abort_memwrite", memWrite, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ack0", ack0, 0);
    @(negedge clk);
    checkOutput("abort_noack", ack0 || ack1, 0);
    reset = 1'b0;
    waitAck(0, 8, lat);
    checkOutput("abort_first_port0", lat, 3);
    checkOutput("abort_first_ack1", ack1, 0);
    checkOutput("abort_first_err", err0, 0);
    req0 = 1'b0;
    waitAck(1, 8, lat);
    checkOutput("abort_second_port1", lat, 4);
    checkOutput("abort_second_rdata", rdata1, 8'hA5);
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", busy, 0);

    $display("[TB] back-to-back on one port");
    req0 = 1'b1; addr0 = 8'h05; write0 = 1'b0;
    @(negedge clk);
    addr0 = 8'h10;
    waitAck(0, 8, lat);
    checkOutput("b2b_first_lat", lat, 2);
    checkOutput("b2b_first_rdata", rdata0, 8'hA5);
    addr0 = 8'h81;
    waitAck(0, 8, lat);
    checkOutput("b2b_second_gap", lat, 4);
    checkOutput("b2b_second_rdata", rdata0, 8'h5A);
    checkOutput("b2b_second_err", err0, 0);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
